// File: rtl/attempt_limiter.sv
`timescale 1ns/1ps
// attempt_limiter
// Failed-attempt tracker for the combination lock. It counts incorrect-code
// pulses and shows the count on a thermometer LED bar. When the limit is
// reached it blocks the keypad for a lockout period. That period doubles on
// each consecutive lockout, up to a saturation level.
//
// Ports
//   clk5            5 MHz system clock
//   reset           synchronous, active-high
//   attempt_fail    one-cycle pulse per incorrect code entry
//   unlock_ok       one-cycle pulse, correct code entered
//   inside_pb       debounced inside-door button (level)
//   attempts_led    thermometer bar, bit i set when failures > i
//   locked          keypad blocked
//   lock_level      consecutive lockouts since the last clear (saturating)
//   lock_remaining  cycles left in the current lockout, 0 when not locked
//   lock_expire     one-cycle pulse in the first cycle after a lockout times out
module attempt_limiter #(
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES  = 25000000,
  parameter int MAX_LEVEL    = 3,
  parameter int CNT_W        = 28,
  localparam int LW = (MAX_LEVEL > 0) ? $clog2(MAX_LEVEL + 1) : 1
) (
  input  logic                    clk5,
  input  logic                    reset,
  input  logic                    attempt_fail,
  input  logic                    unlock_ok,
  input  logic                    inside_pb,
  output logic [MAX_ATTEMPTS-1:0] attempts_led,
  output logic                    locked,
  output logic [LW-1:0]           lock_level,
  output logic [CNT_W-1:0]        lock_remaining,
  output logic                    lock_expire
);

  localparam int FW = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS) : 1;
  localparam logic [FW-1:0]    FAIL_LAST = FW'(MAX_ATTEMPTS - 1);
  localparam logic [LW-1:0]    LEVEL_MAX = LW'(MAX_LEVEL);
  localparam logic [CNT_W-1:0] BASE      = CNT_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  // Longest lockout, computed wide so the fit check itself cannot overflow.
  localparam logic [63:0]      MAX_LOAD  = 64'(LOCK_CYCLES) << MAX_LEVEL;

  if (MAX_ATTEMPTS < 1) begin : g_chk_att
    $error("attempt_limiter: MAX_ATTEMPTS must be >= 1");
  end
  if (LOCK_CYCLES < 1) begin : g_chk_lock
    $error("attempt_limiter: LOCK_CYCLES must be >= 1");
  end
  if ((MAX_LOAD >> CNT_W) != 64'd0) begin : g_chk_w
    $error("attempt_limiter: CNT_W too narrow for LOCK_CYCLES<<MAX_LEVEL");
  end

  typedef enum logic {ARMED, LOCKED} state_t;

  state_t                  state, state_n;
  logic [FW-1:0]           fail_cnt, fail_cnt_n;
  logic [LW-1:0]           level_n;
  logic [CNT_W-1:0]        rem_n;
  logic                    locked_n;
  logic                    expire_n;
  logic [MAX_ATTEMPTS-1:0] led_n;

  always_ff @(posedge clk5) begin
    if (reset) begin
      state          <= ARMED;
      fail_cnt       <= '0;
      attempts_led   <= '0;
      locked         <= 1'b0;
      lock_level     <= '0;
      lock_remaining <= '0;
      lock_expire    <= 1'b0;
    end else begin
      state          <= state_n;
      fail_cnt       <= fail_cnt_n;
      attempts_led   <= led_n;
      locked         <= locked_n;
      lock_level     <= level_n;
      lock_remaining <= rem_n;
      lock_expire    <= expire_n;
    end
  end

  always_comb begin
    state_n    = state;
    fail_cnt_n = fail_cnt;
    level_n    = lock_level;
    rem_n      = lock_remaining;
    expire_n   = 1'b0;
    case (state)
      ARMED: begin
        // A failure wins over a simultaneous clear.
        if (attempt_fail) begin
          if (fail_cnt == FAIL_LAST) begin
            state_n    = LOCKED;
            fail_cnt_n = '0;
            // Shift uses the level before this lockout's increment.
            rem_n      = BASE << lock_level;
          end else begin
            fail_cnt_n = fail_cnt + FW'(1);
          end
        end else if (unlock_ok || inside_pb) begin
          fail_cnt_n = '0;
          level_n    = '0;
        end
      end
      LOCKED: begin
        // Keypad is blocked: only the trusted inside button is honoured.
        // It also wins on the final count cycle, so no expire pulse then.
        if (inside_pb) begin
          state_n = ARMED;
          level_n = '0;
          rem_n   = '0;
        end else if (lock_remaining == ONE) begin
          state_n  = ARMED;
          rem_n    = '0;
          expire_n = 1'b1;
          if (lock_level != LEVEL_MAX) level_n = lock_level + LW'(1);
        end else begin
          rem_n = lock_remaining - ONE;
        end
      end
      default: state_n = ARMED;
    endcase
    locked_n = (state_n == LOCKED);
  end

  // Bar shows the next fail count; forced full while locked.
  for (genvar i = 0; i < MAX_ATTEMPTS; i++) begin : g_led
    assign led_n[i] = locked_n | (int'(fail_cnt_n) > i);
  end

endmodule
